// File: rtl/cs_pkg.sv
// Shared types and sizing for the CS window sequencer: FSM states, window/sample/result widths.
package cs_pkg;
  localparam int WIN    = 9;
  localparam int XW     = 8;
  localparam int YW     = 10;
  localparam int FILL_W = 4;

  typedef enum logic [1:0] {CLEAR, FILL, RUN} state_t;
endpackage

// File: rtl/cs_out_slot.sv
// One-entry registered output slot with valid/ready handshake and synchronous drop.
module cs_out_slot #(
  parameter int YW = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [YW-1:0] data,
  input  logic          out_ready,
  input  logic          drop,
  output logic          out_valid,
  output logic [YW-1:0] out_y,
  output logic          free
);
  logic          r_valid;
  logic [YW-1:0] r_y;

  // drop wins over a coincident load so a flushed result never escapes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_y     <= '0;
    end else if (drop) begin
      r_valid <= 1'b0;
    end else if (load) begin
      r_valid <= 1'b1;
      r_y     <= data;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid = r_valid;
  assign out_y     = r_y;
  assign free      = !r_valid || out_ready;
endmodule

// File: rtl/cs_window_ctrl.sv
// Stream sequencer for the 9-tap CS datapath: warm-up gating, pend flag and output slot.
// Optional CS_WIN_CTRL_STAT_EN adds a saturating 16-bit stall_cnt output.
module cs_window_ctrl
  import cs_pkg::*;
#(
  parameter int WIN = cs_pkg::WIN,
  parameter int XW  = cs_pkg::XW,
  parameter int YW  = cs_pkg::YW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XW-1:0]     in_data,
  input  logic              flush,
  output logic              dp_en,
  output logic              dp_clr,
  output logic [XW-1:0]     dp_x,
  input  logic [YW-1:0]     dp_y,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [YW-1:0]     out_y,
`ifdef CS_WIN_CTRL_STAT_EN
  output logic [15:0]       stall_cnt,
`endif
  output logic [FILL_W-1:0] fill_cnt
);
  localparam logic [FILL_W-1:0] LP_WIN_M1 = FILL_W'(WIN - 1);

  state_t            r_state;
  logic [FILL_W-1:0] r_fill_cnt;
  logic              r_pend;
  logic              w_free;
  logic              w_in_ready;
  logic              w_accept;
  logic              w_capture;

  // while pend is stuck behind a full slot the datapath must not advance
  assign w_in_ready = !flush && ((r_state == FILL) ||
                                 ((r_state == RUN) && (!r_pend || w_free)));
  assign w_accept   = in_valid && w_in_ready;
  assign w_capture  = r_pend && w_free && !flush;

  assign in_ready = w_in_ready;
  assign dp_en    = w_accept;
  assign dp_x     = in_data;
  assign dp_clr   = (r_state == CLEAR);
  assign fill_cnt = r_fill_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= CLEAR;
      r_fill_cnt <= '0;
      r_pend     <= 1'b0;
    end else if (flush) begin
      r_state    <= CLEAR;
      r_fill_cnt <= '0;
      r_pend     <= 1'b0;
    end else begin
      case (r_state)
        CLEAR: r_state <= FILL;
        FILL: begin
          if (w_accept) begin
            r_fill_cnt <= r_fill_cnt + 1'b1;
            if (r_fill_cnt == LP_WIN_M1) begin
              r_state <= RUN;
              r_pend  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (w_capture)     r_pend <= w_accept;
          else if (w_accept) r_pend <= 1'b1;
        end
        default: r_state <= CLEAR;
      endcase
    end
  end

  cs_out_slot #(.YW(YW)) u_slot (
    .clk       (clk),
    .reset     (reset),
    .load      (w_capture),
    .data      (dp_y),
    .out_ready (out_ready),
    .drop      (flush),
    .out_valid (out_valid),
    .out_y     (out_y),
    .free      (w_free)
  );

`ifdef CS_WIN_CTRL_STAT_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (flush) begin
      r_stall_cnt <= '0;
    end else if (out_valid && !out_ready && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif
endmodule

// File: tb/tb_cs_window_ctrl.sv
// Directed bench for cs_window_ctrl with a behavioural 9-tap sum>>2 datapath model.
// Define CS_WIN_CTRL_STAT_EN to also check the stall counter.
module tb_cs_window_ctrl;
  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       flush;
  logic       dp_en;
  logic       dp_clr;
  logic [7:0] dp_x;
  logic [9:0] dp_y;
  logic       out_valid;
  logic       out_ready;
  logic [9:0] out_y;
  logic [3:0] fill_cnt;
`ifdef CS_WIN_CTRL_STAT_EN
  logic [15:0] stall_cnt;
`endif

  int n_chk  = 0;
  int n_pass = 0;
  int n_acc  = 0;
  int n_del  = 0;
  int acc0, del0;

  cs_window_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .flush     (flush),
    .dp_en     (dp_en),
    .dp_clr    (dp_clr),
    .dp_x      (dp_x),
    .dp_y      (dp_y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
`ifdef CS_WIN_CTRL_STAT_EN
    .stall_cnt (stall_cnt),
`endif
    .fill_cnt  (fill_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // datapath model: 9-sample window, result = sum >> 2
  logic [7:0] win [9];
  always @(posedge clk) begin
    if (dp_clr) begin
      for (int i = 0; i < 9; i++) win[i] <= 8'd0;
    end else if (dp_en) begin
      win[0] <= dp_x;
      for (int i = 1; i < 9; i++) win[i] <= win[i-1];
    end
  end
  always_comb begin
    int s;
    s = 0;
    for (int i = 0; i < 9; i++) s += int'(win[i]);
    dp_y = 10'(s >> 2);
  end

  always @(posedge clk) begin
    if (dp_en) n_acc <= n_acc + 1;
    if (out_valid && out_ready) n_del <= n_del + 1;
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = 8'd0; flush = 1'b0; out_ready = 1'b1;

    // 1: reset and warm-up
    repeat (2) step();
    check("rst_dp_clr", int'(dp_clr), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_fill_cnt", int'(fill_cnt), 0);
    check("rst_out_y", int'(out_y), 0);
    check("rst_in_ready", int'(in_ready), 0);
    reset = 1'b0;
    #1;
    check("rel_dp_clr_hi", int'(dp_clr), 1);
    step();
    check("rel_dp_clr_lo", int'(dp_clr), 0);
    check("fill_in_ready", int'(in_ready), 1);
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1; in_data = 8'd10;
      step();
      check($sformatf("warm_no_valid_%0d", i + 1), int'(out_valid), 0);
    end
    check("warm_fill_cnt", int'(fill_cnt), 9);
    in_valid = 1'b0;
    step();
    check("first_valid", int'(out_valid), 1);
    check("first_y", int'(out_y), 22);

    // 2: backpressure
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'd10;
    acc0 = n_acc; del0 = n_del;
    #1;
    check("bp_ready_before", int'(in_ready), 1);
    step();
    check("bp_ready_full", int'(in_ready), 0);
    check("bp_dp_en", int'(dp_en), 0);
    repeat (3) step();
    check("bp_hold_valid", int'(out_valid), 1);
    check("bp_hold_y", int'(out_y), 22);
    check("bp_still_blocked", int'(in_ready), 0);
    check("bp_accepts", n_acc - acc0, 1);
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    check("bp_rel1_valid", int'(out_valid), 1);
    check("bp_rel1_y", int'(out_y), 22);
    step();
    check("bp_rel2_empty", int'(out_valid), 0);
    check("bp_delivered", n_del - del0, 2);

    // streaming at one result per cycle with new data
    in_valid = 1'b1; in_data = 8'd20;
    step();
    in_data = 8'd30;
    step();
    check("str_y25_valid", int'(out_valid), 1);
    check("str_y25", int'(out_y), 25);
    in_valid = 1'b0;
    step();
    check("str_y30", int'(out_y), 30);
    check("str_y30_valid", int'(out_valid), 1);
    step();
    check("str_drain", int'(out_valid), 0);

    // 3: flush in RUN with a result in the slot
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'd10;
    step();
    in_valid = 1'b0;
    step();
    check("fl_pre_valid", int'(out_valid), 1);
    flush = 1'b1;
    #1;
    check("fl_in_ready", int'(in_ready), 0);
    step();
    flush = 1'b0;
    check("fl_slot_cleared", int'(out_valid), 0);
    check("fl_fill_cnt", int'(fill_cnt), 0);
    check("fl_dp_clr_hi", int'(dp_clr), 1);
    step();
    check("fl_dp_clr_lo", int'(dp_clr), 0);
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1; in_data = 8'd40;
      step();
      check($sformatf("fl_warm_%0d", i + 1), int'(out_valid), 0);
    end
    in_valid = 1'b0;
    step();
    check("fl_new_valid", int'(out_valid), 1);
    check("fl_new_y", int'(out_y), 90);

    // 4: flush coincident with in_valid
    in_valid = 1'b1; in_data = 8'd7; flush = 1'b1;
    acc0 = n_acc;
    #1;
    check("fv_in_ready", int'(in_ready), 0);
    check("fv_dp_en", int'(dp_en), 0);
    step();
    flush = 1'b0;
    step();
    check("fv_not_accepted", n_acc - acc0, 0);
    check("fv_fill_zero", int'(fill_cnt), 0);
    step();
    check("fv_fill_one", int'(fill_cnt), 1);
    step();
    flush = 1'b1;
    #1;
    check("fv2_dp_en", int'(dp_en), 0);
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("fv2_fill_zero", int'(fill_cnt), 0);
    step();

    // 5: async reset with pend and a held result
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'd10;
    repeat (9) step();
    step();
    check("ar_pre_valid", int'(out_valid), 1);
    check("ar_pre_pend_block", int'(in_ready), 0);
    #2;
    reset = 1'b1;
    #1;
    check("ar_valid_drop", int'(out_valid), 0);
    check("ar_dp_clr", int'(dp_clr), 1);
    check("ar_fill_cnt", int'(fill_cnt), 0);
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    reset = 1'b0;
    #1;
    check("ar_rel_dp_clr_hi", int'(dp_clr), 1);
    step();
    check("ar_rel_dp_clr_lo", int'(dp_clr), 0);
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1; in_data = 8'd10;
      step();
      check($sformatf("ar_warm_%0d", i + 1), int'(out_valid), 0);
    end
    in_valid = 1'b0;
    step();
    check("ar_restart_valid", int'(out_valid), 1);
    check("ar_restart_y", int'(out_y), 22);
    check("ar_restart_fill", int'(fill_cnt), 9);

    // 6: stalled slot for 20 cycles
    out_ready = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0;
    step();
`ifdef CS_WIN_CTRL_STAT_EN
    check("st_cleared", int'(stall_cnt), 0);
`endif
    in_valid = 1'b1; in_data = 8'd10;
    repeat (9) step();
    in_valid = 1'b0;
    step();
    check("st_valid", int'(out_valid), 1);
    repeat (20) step();
    check("st_hold_valid", int'(out_valid), 1);
    check("st_hold_y", int'(out_y), 22);
`ifdef CS_WIN_CTRL_STAT_EN
    check("st_count20", int'(stall_cnt), 20);
`endif
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("st_flush_valid", int'(out_valid), 0);
`ifdef CS_WIN_CTRL_STAT_EN
    check("st_flush_zero", int'(stall_cnt), 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
